// File: rtl/weight_fetch_pkg.sv
// rtl/weight_fetch_pkg.sv - shared widths and sequencer states for the weight fetch path
package weight_fetch_pkg;

   localparam int WF_ADDR_W = 11;
   localparam int WF_DEPTH  = 1440;
   localparam int WF_DATA_W = 18;

   typedef enum logic [1:0] {
      WF_IDLE  = 2'd0,
      WF_RUN   = 2'd1,
      WF_DRAIN = 2'd2,
      WF_DONE  = 2'd3
   } wf_state_e;

endpackage

// File: rtl/weight_skid_fifo.sv
// rtl/weight_skid_fifo.sv - 2-entry FIFO absorbing ROM latency and MAC backpressure
module weight_skid_fifo
   import weight_fetch_pkg::*;
#(
   parameter int DATA_W = WF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (count_q == 2'd0);
   assign count = count_q;

endmodule

// File: rtl/weight_fetch.sv
// rtl/weight_fetch.sv - streams one layer's weights from the synchronous ROM to the MAC array
module weight_fetch
   import weight_fetch_pkg::*;
#(
   parameter int ADDR_W = WF_ADDR_W,
   parameter int DEPTH  = WF_DEPTH,
   parameter int DATA_W = WF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] len,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic [DATA_W-1:0] w_data,
   output logic              w_valid,
   input  logic              w_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   wf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] issued_q, issued_d;
   logic              rd_pend_q, rd_pend_d;

   logic              fifo_empty;
   logic [1:0]        fifo_count;
   logic              pop;
   logic              issue;
   logic              credit_ok;
   logic [2:0]        occ;

   weight_skid_fifo #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_pend_q),
      .din   (rom_q),
      .pop   (pop),
      .dout  (w_data),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign w_valid = !fifo_empty;
   assign pop     = w_valid && w_ready;

   // A pop this cycle frees a slot at the same edge the new read would land.
   assign occ       = {1'b0, fifo_count} + {2'b00, rd_pend_q};
   assign credit_ok = pop || (occ < 3'd2);
   assign issue     = (state_q == WF_RUN) && (issued_q != len_q) && credit_ok;

   assign rom_addr = issue ? nxt_addr_q : last_addr_q;
   assign busy     = (state_q != WF_IDLE);
   assign done     = (state_q == WF_DONE);

   always_comb begin
      state_d     = state_q;
      nxt_addr_d  = nxt_addr_q;
      last_addr_d = last_addr_q;
      len_d       = len_q;
      issued_d    = issued_q;
      rd_pend_d   = issue;
      case (state_q)
         WF_IDLE: begin
            if (start) begin
               len_d      = len;
               nxt_addr_d = base_addr;
               issued_d   = '0;
               state_d    = (len != '0) ? WF_RUN : WF_DONE;
            end
         end
         WF_RUN: begin
            if (issue) begin
               last_addr_d = nxt_addr_q;
               nxt_addr_d  = (nxt_addr_q == ADDR_LAST) ? '0 : nxt_addr_q + ADDR_ONE;
               issued_d    = issued_q + ADDR_ONE;
               if (issued_q + ADDR_ONE == len_q) begin
                  state_d = WF_DRAIN;
               end
            end
         end
         WF_DRAIN: begin
            // Leave as the last word is taken so done lands the following cycle.
            if (!rd_pend_q && (fifo_empty || (fifo_count == 2'd1 && pop))) begin
               state_d = WF_DONE;
            end
         end
         WF_DONE: begin
            state_d = WF_IDLE;
         end
         default: begin
            state_d = WF_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= WF_IDLE;
         nxt_addr_q  <= '0;
         last_addr_q <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         rd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         nxt_addr_q  <= nxt_addr_d;
         last_addr_q <= last_addr_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

endmodule
